// File: rtl/regfile_fifo.sv
// regfile_fifo: single-clock circular-buffer FIFO fed by register-file strobes.
// Push, pop and flush arrive as one-cycle pulses. Overflow and underflow are
// sticky until a flush or reset. A registered head word and an irq level are
// provided for software read-back. Storage is never reset; only control state is.
module regfile_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_pulse,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_pulse,
   input  logic                  clr_pulse,
   input  logic [DEPTH_LOG2:0]   thr,
   output logic [DATA_W-1:0]     rd_data,
   output logic [31:0]           status,
   output logic                  irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;
   logic                  underflow;
   logic                  do_push;
   logic                  do_pop;
   logic                  empty;
   logic                  full;

   // Accept decisions: a pop needs data; a push needs room unless a pop frees a slot in the same cycle.
   always_comb begin
      do_pop  = rd_pulse && (count != '0);
      do_push = wr_pulse && ((count != DEPTH_CNT) || do_pop);
   end

   assign empty  = (count == '0);
   assign full   = (count == DEPTH_CNT);
   assign status = {16'h0000, 8'(count), 4'h0, underflow, overflow, full, empty};

   // Storage write; a flush in the same cycle discards the incoming word.
   always_ff @(posedge clk) begin
      if (do_push && !clr_pulse) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Control state: pointers, occupancy and sticky error flags; flush overrides everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr_pulse) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
         if (wr_pulse && !do_push) begin
            overflow <= 1'b1;
         end
         if (rd_pulse && !do_pop) begin
            underflow <= 1'b1;
         end
      end
   end

   // Registered head word; reads zero while the FIFO is empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
      end else if (count != '0) begin
         rd_data <= mem[rd_ptr];
      end else begin
         rd_data <= '0;
      end
   end

   // Interrupt level from the registered occupancy; a zero threshold disables it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq <= 1'b0;
      end else begin
         irq <= (thr != '0) && (count >= thr);
      end
   end

endmodule
